// File: rtl/jt51_mmr_fifo.sv
// JT51 register write queue: CPU {addr,data} pairs are buffered and drained to the
// register file over a valid/ready handshake with a cen-timed hold-off between commits.
// Optional sticky overflow flag: define JT51_MMR_FIFO_OVF_EN.
module jt51_mmr_fifo #(
    parameter int DEPTH   = 4,
    parameter int AW      = $clog2(DEPTH),
    parameter int WR_WAIT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic [7:0]    d_in,
    input  logic          a0,
    input  logic          write,
    output logic          busy,
    output logic          pending,
    output logic [AW:0]   level,
    output logic [7:0]    reg_addr,
    output logic [7:0]    reg_data,
    output logic          reg_we,
    input  logic          reg_ready,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int            CW       = (WR_WAIT > 1) ? $clog2(WR_WAIT) : 1;
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] CNT_INIT = (WR_WAIT > 0) ? CW'(WR_WAIT - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    state_t        r_state, w_state_nx;
    logic [7:0]    r_sel_addr;
    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_level;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [7:0]    r_reg_addr, r_reg_data;
    logic          w_full, w_push, w_pop, w_refuse, w_load;

    // Full is judged on the registered level, so a same-cycle pop never frees a slot for a push.
    assign w_full   = (r_level == FULL);
    assign w_push   = write & a0 & ~w_full;
    assign w_refuse = write & a0 & w_full;
    assign w_pop    = (r_state == S_ISSUE) & reg_ready;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_load     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_load     = 1'b1;
                    w_state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (reg_ready) begin
                    if (WR_WAIT == 0) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_HOLD;
                        w_cnt_nx   = CNT_INIT;
                    end
                end
            end
            S_HOLD: begin
                if (cen) begin
                    if (r_cnt == '0) w_state_nx = S_IDLE;
                    else             w_cnt_nx   = r_cnt - CW'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_addr <= 8'h00;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_reg_addr <= 8'h00;
            r_reg_data <= 8'h00;
        end else begin
            if (write & ~a0) r_sel_addr <= d_in;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_load) {r_reg_addr, r_reg_data} <= r_mem[r_rd_ptr];
        end
    end

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_sel_addr, d_in};
    end

`ifdef JT51_MMR_FIFO_OVF_EN
    logic r_ovf;
    always_ff @(posedge clk) begin
        if (rst)           r_ovf <= 1'b0;
        else if (w_refuse) r_ovf <= 1'b1;
        else if (ovf_clr)  r_ovf <= 1'b0;
    end
    assign ovf = r_ovf;
`else
    logic w_unused;
    assign w_unused = ovf_clr ^ w_refuse;
    assign ovf      = 1'b0;
`endif

    assign busy     = w_full;
    assign pending  = (r_level != '0) | (r_state != S_IDLE);
    assign level    = r_level;
    assign reg_addr = r_reg_addr;
    assign reg_data = r_reg_data;
    assign reg_we   = (r_state == S_ISSUE);

endmodule

// File: tb/tb_jt51_mmr_fifo.sv
// Scoreboard bench for jt51_mmr_fifo: expected commits are queued at the CPU write,
// a negedge monitor checks every accepted commit and handshake stability.
module tb_jt51_mmr_fifo;
    localparam int DEPTH   = 4;
    localparam int AW      = 2;
    localparam int WR_WAIT = 3;
`ifdef JT51_MMR_FIFO_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b1;
    logic [7:0]    d_in = 8'h00;
    logic          a0 = 1'b0;
    logic          write = 1'b0;
    logic          busy, pending, reg_we, ovf;
    logic [AW:0]   level;
    logic [7:0]    reg_addr, reg_data;
    logic          reg_ready = 1'b1;
    logic          ovf_clr = 1'b0;

    int            ncmp = 0;
    int            nerr = 0;
    int            cyc = 0;
    logic          cen_alt = 1'b0;
    logic [15:0]   exp_q[$];
    int            commit_cyc[$];

    jt51_mmr_fifo #(.DEPTH(DEPTH), .WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .rst(rst), .cen(cen), .d_in(d_in), .a0(a0), .write(write),
        .busy(busy), .pending(pending), .level(level), .reg_addr(reg_addr),
        .reg_data(reg_data), .reg_we(reg_we), .reg_ready(reg_ready),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (cen_alt) cen = ~cen;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cpu_wr(input logic ia0, input logic [7:0] d);
        write = 1'b1;
        a0    = ia0;
        d_in  = d;
        tick();
        write = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            if (!pending) break;
            tick();
        end
        chk("drain_timeout", 32'(pending), 32'd0);
    endtask

    // Monitor: order/content of commits, and stall stability of the presented pair.
    initial begin
        logic        prev_wait;
        logic [15:0] prev_ad;
        logic [15:0] e;
        prev_wait = 1'b0;
        prev_ad   = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_wait && reg_we) begin
                    ncmp++;
                    if ({reg_addr, reg_data} !== prev_ad) begin
                        nerr++;
                        $display("FAIL stall_stable: got %h expected %h", {reg_addr, reg_data}, prev_ad);
                    end
                end
                if (reg_we && reg_ready) begin
                    commit_cyc.push_back(cyc);
                    ncmp++;
                    if (exp_q.size() == 0) begin
                        nerr++;
                        $display("FAIL commit_unexpected: got %h expected none", {reg_addr, reg_data});
                    end else begin
                        e = exp_q.pop_front();
                        if ({reg_addr, reg_data} !== e) begin
                            nerr++;
                            $display("FAIL commit: got %h expected %h", {reg_addr, reg_data}, e);
                        end
                    end
                end
            end
            prev_wait = !rst && reg_we && !reg_ready;
            prev_ad   = {reg_addr, reg_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_addr", 32'(reg_addr), 0);
        chk("rst_data", 32'(reg_data), 0);
        chk("rst_we", 32'(reg_we), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        tick();

        // Single write latency and hold-off
        cpu_wr(1'b0, 8'h20);
        exp_q.push_back(16'h20C7);
        cpu_wr(1'b1, 8'hC7);
        chk("lat_level_n1", 32'(level), 1);
        chk("lat_we_n1", 32'(reg_we), 0);
        tick();
        chk("lat_we_n2", 32'(reg_we), 1);
        chk("lat_addr_n2", 32'(reg_addr), 32'h20);
        chk("lat_data_n2", 32'(reg_data), 32'hC7);
        tick();
        chk("lat_level_n3", 32'(level), 0);
        chk("lat_we_n3", 32'(reg_we), 0);
        chk("lat_pend_n3", 32'(pending), 1);
        tick(); tick();
        chk("hold_pend_n5", 32'(pending), 1);
        tick();
        chk("hold_pend_n6", 32'(pending), 0);

        // Fill past full with the register file stalled
        reg_ready = 1'b0;
        cpu_wr(1'b0, 8'h08);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back({8'h08, 8'(i)});
            cpu_wr(1'b1, 8'(i));
            chk("fill_busy", 32'(busy), (i == 4) ? 32'd1 : 32'd0);
        end
        cpu_wr(1'b1, 8'h05);
        chk("full_level", 32'(level), 4);
        chk("full_busy", 32'(busy), 1);
        chk("full_ovf", 32'(ovf), 32'(OVF_EXP));
        cpu_wr(1'b0, 8'h09);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 0);
        chk("stall_we", 32'(reg_we), 1);
        chk("stall_data", 32'(reg_data), 32'h01);
        reg_ready = 1'b1;
        wait_idle(100);
        exp_q.push_back(16'h09AA);
        cpu_wr(1'b1, 8'hAA);
        wait_idle(50);

        // Pseudo-random ready during ISSUE
        reg_ready = 1'b0;
        cpu_wr(1'b0, 8'h40);
        exp_q.push_back(16'h4011); cpu_wr(1'b1, 8'h11);
        exp_q.push_back(16'h4022); cpu_wr(1'b1, 8'h22);
        exp_q.push_back(16'h4033); cpu_wr(1'b1, 8'h33);
        for (int i = 0; i < 400; i++) begin
            if (!pending) break;
            reg_ready = 1'($urandom_range(0, 1));
            tick();
        end
        reg_ready = 1'b1;
        chk("rand_drained", 32'(pending), 0);
        chk("rand_level", 32'(level), 0);

        // Commit spacing with cen high every other cycle
        reg_ready = 1'b0;
        cpu_wr(1'b0, 8'h60);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({8'h60, 8'(8'hB0 + i)});
            cpu_wr(1'b1, 8'(8'hB0 + i));
        end
        commit_cyc.delete();
        cen_alt   = 1'b1;
        reg_ready = 1'b1;
        wait_idle(200);
        cen_alt = 1'b0;
        cen     = 1'b1;
        chk("cen_ncommit", 32'(commit_cyc.size()), 4);
        if (commit_cyc.size() == 4) begin
            chk("cen_gap2", 32'(commit_cyc[2] - commit_cyc[1]), 8);
            chk("cen_gap3", 32'(commit_cyc[3] - commit_cyc[2]), 8);
        end

        // DEPTH-1 entries, then push and pop in the same cycle
        reg_ready = 1'b0;
        cpu_wr(1'b0, 8'h30);
        exp_q.push_back(16'h30A1); cpu_wr(1'b1, 8'hA1);
        exp_q.push_back(16'h30A2); cpu_wr(1'b1, 8'hA2);
        exp_q.push_back(16'h30A3); cpu_wr(1'b1, 8'hA3);
        chk("pp_level_pre", 32'(level), 3);
        chk("pp_busy_pre", 32'(busy), 0);
        exp_q.push_back(16'h30A4);
        reg_ready = 1'b1;
        cpu_wr(1'b1, 8'hA4);
        reg_ready = 1'b0;
        chk("pp_level_post", 32'(level), 3);
        reg_ready = 1'b1;
        wait_idle(100);

        // Reset during HOLD with three entries queued
        reg_ready = 1'b0;
        cpu_wr(1'b0, 8'h50);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back({8'h50, 8'(i)});
            cpu_wr(1'b1, 8'(i));
        end
        reg_ready = 1'b1;
        tick();
        chk("mid_level", 32'(level), 3);
        chk("mid_we", 32'(reg_we), 0);
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk("mrst_level", 32'(level), 0);
        chk("mrst_we", 32'(reg_we), 0);
        chk("mrst_pending", 32'(pending), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_addr", 32'(reg_addr), 0);
        rst = 1'b0;
        repeat (30) tick();
        chk("post_rst_level", 32'(level), 0);
        chk("post_rst_pending", 32'(pending), 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/jt51_mmr_fifo.md
# jt51_mmr_fifo

Parametrised write front end for the JT51 register map that decouples the CPU bus from register commit timing. CPU address/data writes are queued as {address, data} pairs in a DEPTH-entry FIFO. A drain state machine then presents the pairs one at a time to the register file through a valid/ready handshake, with a programmable hold-off between commits. It sits between the host bus and the memory-mapped register decoder, replacing the single-slot busy latch with a deep queue and an occupancy report.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..64.
- AW, $clog2(DEPTH): pointer width; derived, not overridden.
- WR_WAIT, 32: cen-qualified cycles of hold-off after each commit; 0 allowed.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cen  in  1  clock enable for the WR_WAIT counter only; queue and handshake run every clk.
- d_in  in  8  CPU write data.
- a0  in  1  0 = address write, 1 = data write.
- write  in  1  one-cycle CPU write strobe.
- busy  out  1  FIFO full; CPU must not issue data writes while high.
- pending  out  1  queue non-empty or drain FSM not IDLE.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- reg_addr  out  8  address of the pair being committed.
- reg_data  out  8  data of the pair being committed.
- reg_we  out  1  commit valid.
- reg_ready  in  1  register file accepts the commit.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.

## Operation
- Address write (write & !a0): latches d_in into sel_addr. The write never touches the FIFO and is accepted even when busy is high.
- Data write (write & a0):
  - When not full, pushes {sel_addr, d_in} at wr_ptr and increments wr_ptr and level.
  - sel_addr is kept, so repeated data writes reuse the same address.
- Data write while full is refused and the FIFO is unchanged. A push is refused even if a pop happens in the same cycle; full is evaluated on the pre-cycle level.
- Push and pop in the same cycle: level is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. level saturates neither high nor low because the push/pop guards prevent it.
- Drain FSM states:
  - IDLE: if level != 0, load reg_addr/reg_data from rd_ptr and go to ISSUE.
  - ISSUE: reg_we = 1, and reg_addr/reg_data are held stable until reg_we & reg_ready. In that cycle the entry is popped (rd_ptr+1, level-1) and the FSM goes to HOLD with cnt = WR_WAIT-1. If WR_WAIT = 0 it goes to IDLE instead.
  - HOLD: cnt decrements on cycles with cen = 1. When cnt = 0 and cen = 1, the FSM goes to IDLE.
- reg_we is 0 in every state other than ISSUE.
- pending = (level != 0) | (state != IDLE).

## Timing
- Reset values:
  - Outputs: busy 0, pending 0, level 0, reg_addr 8'h00, reg_data 8'h00, reg_we 0, ovf 0.
  - Internal: sel_addr 8'h00, pointers 0, state IDLE, cnt 0.
- Reset asserted mid-operation discards all queued entries and any in-flight commit. reg_we drops in the next cycle.
- Latency into an empty, IDLE block with reg_ready held at 1:
  - Data write at cycle n, level = 1 at n+1.
  - reg_we high at n+2, commit and pop at n+2.
  - level = 0 at n+3.
- Commit spacing with reg_ready = 1 and cen = 1: back-to-back commits are WR_WAIT+2 cycles apart, or 2 cycles apart for WR_WAIT = 0.
- busy is combinational from registered level (level == DEPTH). It rises the cycle after the push that fills the queue.

## Configuration
- JT51_MMR_FIFO_OVF_EN defined:
  - A refused data write sets ovf at the next cycle.
  - ovf stays set until ovf_clr is high.
  - If ovf_clr and a refused write occur in the same cycle, set wins.
- JT51_MMR_FIFO_OVF_EN undefined: ovf is tied 0, ovf_clr is ignored, and refused writes are dropped silently.

## Test plan
- Reset, then address 8'h20, then data 8'hC7 -> one commit with reg_addr = 8'h20, reg_data = 8'hC7 and reg_we at cycle n+2; level returns to 0 and pending falls after the WR_WAIT hold.
- DEPTH = 4, reg_ready = 0, five data writes to address 8'h08 with data 1..5 -> busy = 1 after the fourth; fifth dropped; ovf = 1 with OVF_EN, 0 without; after reg_ready = 1, commits 1, 2, 3, 4 in order.
- reg_ready toggled pseudo-randomly during ISSUE -> reg_addr/reg_data stay stable while reg_we & !reg_ready; exactly one pop per accepted commit.
- WR_WAIT = 3, cen high one cycle in two -> HOLD lasts 6 clk; next reg_we appears the cycle after HOLD ends.
- Fill to DEPTH-1, then issue a push in the same cycle as a pop -> level unchanged, order preserved across pointer wrap.
- rst asserted while level = 3 and the FSM is in HOLD -> level 0, reg_we 0, and no further commits after release.
